// File: rtl/compare_reload_scheduler_if.sv
// Write-side bus for compare_reload_scheduler: a valid/ready stream of
// threshold words (slot index, value, end-of-set marker).
interface compare_reload_scheduler_if #(
  parameter int COUNTER_WIDTH = 16,
  parameter int N_CHANNELS    = 3
);
  localparam int IDX_W = $clog2(2 * N_CHANNELS);

  logic                     wr_valid;
  logic                     wr_ready;
  logic [IDX_W-1:0]         wr_index;
  logic [COUNTER_WIDTH-1:0] wr_data;
  logic                     wr_last;

  // Register-file side: produces threshold words.
  modport master (
    output wr_valid,
    output wr_index,
    output wr_data,
    output wr_last,
    input  wr_ready
  );

  // Scheduler side: consumes threshold words.
  modport slave (
    input  wr_valid,
    input  wr_index,
    input  wr_data,
    input  wr_last,
    output wr_ready
  );
endinterface

// File: rtl/compare_reload_scheduler.sv
// compare_reload_scheduler
// Collects a complete set of 2*N_CHANNELS comparator thresholds in a staging
// bank and commits it atomically to thresholds_out on a qualifying PWM
// counter event (optionally divided), with a one-cycle reload_compare strobe.
// Optional feature macro: COMPARE_RELOAD_STOPPED_BYPASS_EN -- while the counter
// is stopped and nothing is staged, each write goes straight to the outputs.
module compare_reload_scheduler #(
  parameter int COUNTER_WIDTH = 16,
  parameter int N_CHANNELS    = 3
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          counter_stopped,
  input  logic                                          period_start,
  input  logic                                          period_mid,
  input  logic [1:0]                                    reload_mode,
  input  logic [7:0]                                    reload_divider,
  compare_reload_scheduler_if.slave                     wr,
  input  logic                                          clear_overrun,
  output logic [2*N_CHANNELS-1:0][COUNTER_WIDTH-1:0]    thresholds_out,
  output logic                                          reload_compare,
  output logic                                          update_pending,
  output logic                                          overrun
);

  localparam int DEPTH = 2 * N_CHANNELS;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STAGING = 2'd1,
    ST_ARMED   = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  state_e                                  state_q;
  logic [DEPTH-1:0][COUNTER_WIDTH-1:0]     bank_q;
  logic [DEPTH-1:0][COUNTER_WIDTH-1:0]     thresholds_q;
  logic                                    reload_compare_q;
  logic                                    update_pending_q;
  logic                                    overrun_q;
  logic                                    wr_ready_q;
  logic [7:0]                              event_cnt_q;
  logic [7:0]                              event_cnt_d;
`ifdef COMPARE_RELOAD_STOPPED_BYPASS_EN
  logic                                    bypass_pend_q;
`endif

  logic qual_s;
  logic eligible_s;
  logic accept_s;
  logic idx_ok_s;

  assign wr.wr_ready      = wr_ready_q;
  assign thresholds_out   = thresholds_q;
  assign reload_compare   = reload_compare_q;
  assign update_pending   = update_pending_q;
  assign overrun          = overrun_q;

  // Handshake and slot-range decode (out-of-range slots are accepted but dropped).
  always_comb begin
    accept_s = wr.wr_valid & wr_ready_q;
    idx_ok_s = ({1'b0, wr.wr_index} < (IDX_W + 1)'(DEPTH));
  end

  // Event qualification and divider: start+mid together count as one event;
  // a divider lowered below the running count zeroes it without a commit.
  always_comb begin
    qual_s = 1'b0;
    case (reload_mode)
      2'b00:   qual_s = period_start;
      2'b01:   qual_s = period_mid;
      2'b10:   qual_s = period_start | period_mid;
      default: qual_s = 1'b0;
    endcase
    eligible_s  = qual_s && (event_cnt_q == reload_divider);
    event_cnt_d = event_cnt_q;
    if (qual_s) begin
      if (event_cnt_q >= reload_divider) begin
        event_cnt_d = 8'd0;
      end else begin
        event_cnt_d = event_cnt_q + 8'd1;
      end
    end else begin
      event_cnt_d = event_cnt_q;
    end
  end

  // Main FSM with staging bank, committed thresholds and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      bank_q           <= '0;
      thresholds_q     <= '0;
      reload_compare_q <= 1'b0;
      update_pending_q <= 1'b0;
      overrun_q        <= 1'b0;
      wr_ready_q       <= 1'b1;
      event_cnt_q      <= 8'd0;
`ifdef COMPARE_RELOAD_STOPPED_BYPASS_EN
      bypass_pend_q    <= 1'b0;
`endif
    end else begin
      event_cnt_q <= event_cnt_d;
`ifdef COMPARE_RELOAD_STOPPED_BYPASS_EN
      // A direct write strobes the compare unit one cycle after it lands.
      reload_compare_q <= bypass_pend_q;
      bypass_pend_q    <= 1'b0;
`else
      reload_compare_q <= 1'b0;
`endif

      // An event that finds the set still incomplete is flagged; set beats clear.
      if (eligible_s && (state_q == ST_STAGING)) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
`ifdef COMPARE_RELOAD_STOPPED_BYPASS_EN
            if (counter_stopped) begin
              if (idx_ok_s) begin
                bank_q[wr.wr_index]       <= wr.wr_data;
                thresholds_q[wr.wr_index] <= wr.wr_data;
              end
              bypass_pend_q <= 1'b1;
            end else begin
`endif
              if (idx_ok_s) begin
                bank_q[wr.wr_index] <= wr.wr_data;
              end
              if (wr.wr_last) begin
                state_q          <= ST_ARMED;
                wr_ready_q       <= 1'b0;
                update_pending_q <= 1'b1;
              end else begin
                state_q <= ST_STAGING;
              end
`ifdef COMPARE_RELOAD_STOPPED_BYPASS_EN
            end
`endif
          end
        end

        ST_STAGING: begin
          if (accept_s) begin
            if (idx_ok_s) begin
              bank_q[wr.wr_index] <= wr.wr_data;
            end
            if (wr.wr_last) begin
              state_q          <= ST_ARMED;
              wr_ready_q       <= 1'b0;
              update_pending_q <= 1'b1;
            end
          end
        end

        ST_ARMED: begin
          if (eligible_s || counter_stopped) begin
            state_q          <= ST_COMMIT;
            thresholds_q     <= bank_q;
            reload_compare_q <= 1'b1;
            update_pending_q <= 1'b0;
          end
        end

        ST_COMMIT: begin
          state_q          <= ST_IDLE;
          wr_ready_q       <= 1'b1;
          update_pending_q <= 1'b0;
        end

        default: begin
          state_q          <= ST_IDLE;
          wr_ready_q       <= 1'b1;
          update_pending_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
